afp3_eng_rtry_queue: RTL
========================

AFP3_ENG_RTRY_QUEUE -- requirements
Module: afp3_eng_rtry_queue

Interface
REQ-001 SHALL have port clock, input, 1, single engine clock; all state samples on rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have inputs rsp_val, rsp_cpy_xx, rsp_cpy_st (1 each) and rsp_afutag (5): validated response from response decode.
REQ-004 SHALL have inputs rsp_is_pending, rsp_is_rtry_lwt, rsp_is_rtry_req, rsp_is_rtry_hwt (1 each): response classification.
REQ-005 SHALL have inputs mmio_eng_rtry_backoff_timer (4, backoff exponent) and rtry_decode_is_backoff (1, decoder feedback, valid with rden_dly2).
REQ-006 SHALL have input rtry_queue_rd_stall (1): downstream sequencer busy; no new read launches.
REQ-007 SHALL have outputs rtry_queue_func_rden_dly2_q (1) plus latched entry fields rtry_queue_cpy_xx_q, rtry_queue_cpy_st_q, rtry_queue_afutag_q[4:0], rtry_queue_is_pending_q, rtry_queue_is_rtry_lwt_q, rtry_queue_is_rtry_req_q, rtry_queue_is_rtry_hwt_q.
REQ-008 SHALL have outputs rtry_queue_empty (1), rtry_queue_overflow_err (1, sticky), rtry_queue_backoff_active (1).

Function
REQ-009 SHALL enqueue when rsp_val=1 and any of the four classification bits is 1; other responses ignored.
REQ-010 SHALL store 9-bit entry {cpy_xx, cpy_st, afutag[4:0] replaced by 0 when cpy_xx=1, one-hot class encoded as 2 bits} in a 32-entry circular array with 6-bit wrapping read/write pointers (bit 5 = wrap).
REQ-011 Class priority when several bits set: pending > lwt > req > hwt; exactly one class bit SHALL be 1 on output.
REQ-012 Full = pointers differ only in bit 5; enqueue when full SHALL drop the entry and set rtry_queue_overflow_err until reset.
REQ-013 Read launch (rden) SHALL occur when not empty, no read in flight (rden, rden_dly1, rden_dly2 all 0), rtry_queue_rd_stall=0, backoff not active.
REQ-014 rden SHALL advance the read pointer; array data SHALL be latched into output registers in cycle rden+2, same cycle rtry_queue_func_rden_dly2_q=1 (one cycle pulse).
REQ-015 Simultaneous enqueue and read launch SHALL both occur; entry written this cycle SHALL NOT be readable before next cycle (empty evaluated on registered pointers).
REQ-016 Backoff FSM states IDLE, COUNT: IDLE->COUNT when rden_dly2=1 and rtry_decode_is_backoff=1, loading 16-bit counter with 2^mmio_eng_rtry_backoff_timer; COUNT decrements to 1 then ->IDLE; rtry_queue_backoff_active=1 in COUNT.
REQ-017 Backoff entry SHALL be re-enqueued at write side in the cycle after rden_dly2 (takes priority; a coinciding new response is held one cycle in a single-entry skid register).
REQ-018 Skid register occupied and a further response arriving SHALL count as overflow (REQ-012).
REQ-019 rtry_queue_empty SHALL be combinational from registered pointers and skid valid (empty = pointers equal and skid empty).

Reset
REQ-020 reset_n low SHALL asynchronously clear pointers, skid, rden pipeline, FSM (IDLE), counter, all output registers and overflow_err to 0; rtry_queue_empty=1.
REQ-021 Reset mid-backoff or mid-read SHALL discard the in-flight entry without output pulse.
REQ-022 Array contents need not be reset.

Configuration
REQ-023 Macro AFP3_RTRY_BACKOFF_EN defined: REQ-016/017 backoff delay and re-enqueue as stated.
REQ-024 Macro undefined: FSM, counter absent; rtry_queue_backoff_active tied 0; backoff entries re-enqueued per REQ-017 with zero delay.

Structure
REQ-025 Shared package afp3_eng_pkg SHALL hold queue depth (32), entry width (9), class encodings and AFUTAG encodes.
REQ-026 Array SHALL be sub-module afp3_eng_rtry_queue_array (32x9, 1 write port, 1 registered read port, 1-cycle read latency).

Verification
REQ-027 Reset, then rsp_val with afutag=5'b00110, rtry_req=1 -> rden 1 cycle later, dly2 pulse at +3 with afutag_q=5'b00110, is_rtry_req_q=1.
REQ-028 33 back-to-back hwt responses, rd_stall=1 -> 32 stored, overflow_err=1 on 33rd, remains 1 after rd_stall released.
REQ-029 cpy_xx=1, cpy_st=1, afutag=5'b10101, pending=1 and lwt=1 -> output cpy_st_q=1, afutag_q=0, is_pending_q=1 only.
REQ-030 Timer=4, backoff feedback on dly2 -> backoff_active high exactly 16 cycles, entry re-read after; macro undefined -> re-read with no gap.
REQ-031 Fill to pointer wrap (40 enqueue/dequeue pairs) -> FIFO order preserved, empty=1 at end.
REQ-032 reset_n asserted during rden_dly1 -> no dly2 pulse, empty=1.

Source files
------------

// File: rtl/afp3_eng_pkg.sv
// Shared engine definitions: retry queue geometry, entry layout, class and AFUTAG encodes.
package afp3_eng_pkg;

    localparam int unsigned RTRY_DEPTH      = 32;
    localparam int unsigned RTRY_ADDR_W     = 5;
    localparam int unsigned RTRY_PTR_W      = 6;
    localparam int unsigned RTRY_ENTRY_W    = 9;
    localparam int unsigned AFUTAG_W        = 5;
    localparam int unsigned BACKOFF_TIMER_W = 4;
    localparam int unsigned BACKOFF_CNT_W   = 16;

    // AFUTAG stored for cpy_xx responses, whose tag carries no meaning
    localparam logic [AFUTAG_W-1:0] AFUTAG_CPY_XX = 5'b00000;

    typedef enum logic [1:0] {
        CLS_PENDING = 2'd0,
        CLS_LWT     = 2'd1,
        CLS_REQ     = 2'd2,
        CLS_HWT     = 2'd3
    } rtry_cls_e;

    typedef struct packed {
        logic pending;
        logic lwt;
        logic req;
        logic hwt;
    } rtry_cls_oh_t;

    typedef struct packed {
        logic                cpy_xx;
        logic                cpy_st;
        logic [AFUTAG_W-1:0] afutag;
        rtry_cls_e           cls;
    } rtry_entry_t;

    // Priority pending > lwt > req > hwt
    function automatic rtry_cls_e cls_encode(input rtry_cls_oh_t oh);
        rtry_cls_e cls;
        if (oh.pending) begin
            cls = CLS_PENDING;
        end else if (oh.lwt) begin
            cls = CLS_LWT;
        end else if (oh.req) begin
            cls = CLS_REQ;
        end else begin
            cls = CLS_HWT;
        end
        return cls;
    endfunction

    function automatic rtry_cls_oh_t cls_decode(input rtry_cls_e cls);
        rtry_cls_oh_t oh;
        oh = '0;
        case (cls)
            CLS_PENDING: oh.pending = 1'b1;
            CLS_LWT:     oh.lwt     = 1'b1;
            CLS_REQ:     oh.req     = 1'b1;
            default:     oh.hwt     = 1'b1;
        endcase
        return oh;
    endfunction

    function automatic rtry_entry_t make_entry(
        input logic                cpy_xx,
        input logic                cpy_st,
        input logic [AFUTAG_W-1:0] afutag,
        input rtry_cls_oh_t        oh
    );
        rtry_entry_t e;
        e.cpy_xx = cpy_xx;
        e.cpy_st = cpy_st;
        e.afutag = cpy_xx ? AFUTAG_CPY_XX : afutag;
        e.cls    = cls_encode(oh);
        return e;
    endfunction

endpackage

// File: rtl/afp3_eng_rtry_queue_array.sv
// Retry queue storage: 32x9, one write port, one registered read port (1-cycle latency).
module afp3_eng_rtry_queue_array
    import afp3_eng_pkg::*;
(
    input  logic                   clock,
    input  logic                   wr_en,
    input  logic [RTRY_ADDR_W-1:0] wr_addr,
    input  rtry_entry_t            wr_data,
    input  logic                   rd_en,
    input  logic [RTRY_ADDR_W-1:0] rd_addr,
    output rtry_entry_t            rd_data_q
);

    logic [RTRY_ENTRY_W-1:0] mem [RTRY_DEPTH];

    // Contents are don't-care after reset; only pointers define validity
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (rd_en) begin
            rd_data_q <= rtry_entry_t'(mem[rd_addr]);
        end
    end

endmodule

// File: rtl/afp3_eng_rtry_queue.sv
// Engine retry queue: buffers retry-class responses, replays them to the sequencer,
// and re-enqueues backoff entries. Optional backoff delay under AFP3_RTRY_BACKOFF_EN.
module afp3_eng_rtry_queue
    import afp3_eng_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       rsp_val,
    input  logic                       rsp_cpy_xx,
    input  logic                       rsp_cpy_st,
    input  logic [AFUTAG_W-1:0]        rsp_afutag,
    input  logic                       rsp_is_pending,
    input  logic                       rsp_is_rtry_lwt,
    input  logic                       rsp_is_rtry_req,
    input  logic                       rsp_is_rtry_hwt,
    input  logic [BACKOFF_TIMER_W-1:0] mmio_eng_rtry_backoff_timer,
    input  logic                       rtry_decode_is_backoff,
    input  logic                       rtry_queue_rd_stall,
    output logic                       rtry_queue_func_rden_dly2_q,
    output logic                       rtry_queue_cpy_xx_q,
    output logic                       rtry_queue_cpy_st_q,
    output logic [AFUTAG_W-1:0]        rtry_queue_afutag_q,
    output logic                       rtry_queue_is_pending_q,
    output logic                       rtry_queue_is_rtry_lwt_q,
    output logic                       rtry_queue_is_rtry_req_q,
    output logic                       rtry_queue_is_rtry_hwt_q,
    output logic                       rtry_queue_empty,
    output logic                       rtry_queue_overflow_err,
    output logic                       rtry_queue_backoff_active
);

    logic [RTRY_PTR_W-1:0] wr_ptr_q;
    logic [RTRY_PTR_W-1:0] rd_ptr_q;
    logic                  ptr_eq;
    logic                  full;

    rtry_cls_oh_t          rsp_cls_oh;
    logic                  rsp_enq;
    rtry_entry_t           rsp_entry;

    logic                  skid_vld_q;
    rtry_entry_t           skid_entry_q;
    logic                  skid_vld_d;
    rtry_entry_t           skid_entry_d;

    logic                  reenq_q;
    rtry_entry_t           out_entry_q;

    logic                  wr_req;
    logic                  wr_en;
    rtry_entry_t           wr_entry;
    logic                  ovf_set;

    logic                  rden;
    logic                  rden_dly1_q;
    rtry_entry_t           arr_rd_data;
    rtry_cls_oh_t          arr_rd_oh;

    // Pointer status from registered pointers only, so a same-cycle write is not yet visible
    assign ptr_eq           = (wr_ptr_q == rd_ptr_q);
    assign full             = (wr_ptr_q[RTRY_PTR_W-1] != rd_ptr_q[RTRY_PTR_W-1]) &&
                              (wr_ptr_q[RTRY_ADDR_W-1:0] == rd_ptr_q[RTRY_ADDR_W-1:0]);
    assign rtry_queue_empty = ptr_eq & ~skid_vld_q;

    assign rsp_cls_oh = {rsp_is_pending, rsp_is_rtry_lwt, rsp_is_rtry_req, rsp_is_rtry_hwt};
    assign rsp_enq    = rsp_val & (rsp_is_pending | rsp_is_rtry_lwt | rsp_is_rtry_req | rsp_is_rtry_hwt);
    assign rsp_entry  = make_entry(rsp_cpy_xx, rsp_cpy_st, rsp_afutag, rsp_cls_oh);

    // Write-port arbitration: backoff re-enqueue, then skid drain, then new response
    always_comb begin
        wr_req       = 1'b0;
        wr_entry     = rsp_entry;
        skid_vld_d   = skid_vld_q;
        skid_entry_d = skid_entry_q;
        ovf_set      = 1'b0;
        if (reenq_q) begin
            wr_req   = 1'b1;
            wr_entry = out_entry_q;
            if (rsp_enq) begin
                if (skid_vld_q) begin
                    ovf_set = 1'b1;
                end else begin
                    skid_vld_d   = 1'b1;
                    skid_entry_d = rsp_entry;
                end
            end
        end else if (skid_vld_q) begin
            wr_req     = 1'b1;
            wr_entry   = skid_entry_q;
            skid_vld_d = 1'b0;
            if (rsp_enq) begin
                ovf_set = 1'b1;
            end
        end else if (rsp_enq) begin
            wr_req = 1'b1;
        end
        wr_en = wr_req & ~full;
        if (wr_req && full) begin
            ovf_set = 1'b1;
        end
    end

    // Launch only when the array holds data and no read is in flight
    assign rden = ~ptr_eq & ~rden_dly1_q & ~rtry_queue_func_rden_dly2_q &
                  ~rtry_queue_rd_stall & ~rtry_queue_backoff_active;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q                <= '0;
            rd_ptr_q                <= '0;
            skid_vld_q              <= 1'b0;
            skid_entry_q            <= '0;
            rtry_queue_overflow_err <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + RTRY_PTR_W'(1);
            end
            if (rden) begin
                rd_ptr_q <= rd_ptr_q + RTRY_PTR_W'(1);
            end
            skid_vld_q   <= skid_vld_d;
            skid_entry_q <= skid_entry_d;
            if (ovf_set) begin
                rtry_queue_overflow_err <= 1'b1;
            end
        end
    end

    afp3_eng_rtry_queue_array u_array (
        .clock     (clock),
        .wr_en     (wr_en),
        .wr_addr   (wr_ptr_q[RTRY_ADDR_W-1:0]),
        .wr_data   (wr_entry),
        .rd_en     (rden),
        .rd_addr   (rd_ptr_q[RTRY_ADDR_W-1:0]),
        .rd_data_q (arr_rd_data)
    );

    assign arr_rd_oh = cls_decode(arr_rd_data.cls);

    // Read pipeline and output latch; entry kept whole for backoff re-enqueue
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rden_dly1_q                 <= 1'b0;
            rtry_queue_func_rden_dly2_q <= 1'b0;
            reenq_q                     <= 1'b0;
            out_entry_q                 <= '0;
            rtry_queue_cpy_xx_q         <= 1'b0;
            rtry_queue_cpy_st_q         <= 1'b0;
            rtry_queue_afutag_q         <= '0;
            rtry_queue_is_pending_q     <= 1'b0;
            rtry_queue_is_rtry_lwt_q    <= 1'b0;
            rtry_queue_is_rtry_req_q    <= 1'b0;
            rtry_queue_is_rtry_hwt_q    <= 1'b0;
        end else begin
            rden_dly1_q                 <= rden;
            rtry_queue_func_rden_dly2_q <= rden_dly1_q;
            reenq_q                     <= rtry_queue_func_rden_dly2_q & rtry_decode_is_backoff;
            if (rden_dly1_q) begin
                out_entry_q              <= arr_rd_data;
                rtry_queue_cpy_xx_q      <= arr_rd_data.cpy_xx;
                rtry_queue_cpy_st_q      <= arr_rd_data.cpy_st;
                rtry_queue_afutag_q      <= arr_rd_data.afutag;
                rtry_queue_is_pending_q  <= arr_rd_oh.pending;
                rtry_queue_is_rtry_lwt_q <= arr_rd_oh.lwt;
                rtry_queue_is_rtry_req_q <= arr_rd_oh.req;
                rtry_queue_is_rtry_hwt_q <= arr_rd_oh.hwt;
            end
        end
    end

`ifdef AFP3_RTRY_BACKOFF_EN
    typedef enum logic {
        BO_IDLE  = 1'b0,
        BO_COUNT = 1'b1
    } bo_state_e;

    bo_state_e                bo_state_q;
    bo_state_e                bo_state_d;
    logic [BACKOFF_CNT_W-1:0] bo_cnt_q;
    logic [BACKOFF_CNT_W-1:0] bo_cnt_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bo_state_q                <= BO_IDLE;
            bo_cnt_q                  <= '0;
            rtry_queue_backoff_active <= 1'b0;
        end else begin
            bo_state_q                <= bo_state_d;
            bo_cnt_q                  <= bo_cnt_d;
            rtry_queue_backoff_active <= (bo_state_d == BO_COUNT);
        end
    end

    // Hold off new launches for 2^timer cycles after a backoff decode
    always_comb begin
        bo_state_d = bo_state_q;
        bo_cnt_d   = bo_cnt_q;
        case (bo_state_q)
            BO_IDLE: begin
                if (rtry_queue_func_rden_dly2_q && rtry_decode_is_backoff) begin
                    bo_state_d = BO_COUNT;
                    bo_cnt_d   = BACKOFF_CNT_W'(1) << mmio_eng_rtry_backoff_timer;
                end
            end
            BO_COUNT: begin
                if (bo_cnt_q <= BACKOFF_CNT_W'(1)) begin
                    bo_state_d = BO_IDLE;
                    bo_cnt_d   = '0;
                end else begin
                    bo_cnt_d = bo_cnt_q - BACKOFF_CNT_W'(1);
                end
            end
            default: begin
                bo_state_d = BO_IDLE;
                bo_cnt_d   = '0;
            end
        endcase
    end
`else
    logic unused_backoff_timer;

    assign unused_backoff_timer      = ^mmio_eng_rtry_backoff_timer;
    assign rtry_queue_backoff_active = 1'b0;
`endif

endmodule
